collision_scanner: RTL and testbench
====================================

// Module: collision_scanner
// PURPOSE
//  Next-generation collision engine for the dragon game. It snapshots all entity positions on each
//  frame_start and scans NSEG dragon segments sequentially, one per clock. It produces per-frame
//  collision levels and cooldown-gated single-cycle event pulses (player hurt, dragon hit, dragon heal).
//  These pulses replace the ad-hoc edge-detect flops in the top level and feed Hearts and DragonBody.
// PARAMETERS
//  NSEG      7   number of dragon segments scanned; segment 0 = head
//  POSW      8   position width, packed xxxx_yyyy
//  COOLDOWN  30  frames an event type is suppressed after firing; 0 = plain rising-edge detect
//  (derived) IW = max(1,$clog2(NSEG)), CW = max(1,$clog2(COOLDOWN+1))
// PORTS
//  clk              in   1          system clock
//  rst_n            in   1          reset, synchronous, active-low
//  frame_start      in   1          one-cycle pulse that starts a scan (vsync edge)
//  player_pos       in   POSW       player tile position
//  sword_pos        in   POSW       sword tile position
//  sword_active     in   1          sword is visible/attacking
//  sheep_pos        in   POSW       sheep tile position
//  seg_pos          in   NSEG*POSW  segment positions; segment i at [i*POSW +: POSW]
//  seg_active       in   NSEG       segment i is visible
//  busy             out  1          scan in progress
//  done             out  1          one-cycle pulse; results updated this cycle
//  player_hit       out  1          level: player overlapped an active segment in last scan
//  sword_hit        out  1          level: active sword overlapped an active segment
//  sheep_hit        out  1          level: sheep overlapped the active head (segment 0)
//  player_hurt_evt  out  1          pulse with done
//  dragon_hit_evt   out  1          pulse with done
//  dragon_heal_evt  out  1          pulse with done
//  hit_seg_idx      out  IW         lowest segment index hit by the sword
// BEHAVIOUR
//  Reset (rst_n=0 at a clk edge):
//   - FSM goes to IDLE; all outputs 0; accumulators, previous levels and cooldown counters 0.
//   - Reset mid-scan aborts the scan; done is not produced.
//  FSM IDLE -> SCAN -> REPORT -> IDLE:
//   - IDLE: when frame_start=1, snapshot all position inputs, sword_active and seg_active.
//     Set idx=0, clear accumulators, go to SCAN.
//   - SCAN: one segment per cycle on the snapshot. If seg_active[idx]:
//       - acc_p |= seg==player
//       - acc_s |= sword_active & seg==sword; hit index records the first idx where this matches
//       - if idx==0, acc_h = seg==sheep
//     Go to REPORT when idx==NSEG-1.
//   - REPORT: exactly one cycle. Load the level outputs from the accumulators. Evaluate events.
//     Drive done=1. Go to IDLE.
//  Latency and busy:
//   - Outputs and done update on the (NSEG+1)th rising edge after the edge that sampled frame_start.
//   - busy=1 from the edge after frame_start until the REPORT edge.
//   - frame_start while busy is ignored; there is no restart or queueing.
//  Events, evaluated independently per type (hurt/player, hit/sword, heal/sheep):
//   - evt = level_new & ~level_prev & (cd==0).
//   - On evt, load cd with COOLDOWN. Otherwise decrement cd by 1 each REPORT while cd!=0.
//   - level_prev updates every REPORT.
//   - With COOLDOWN=0, an event is a pure rising edge.
//   - Event pulses coincide with done and are otherwise 0.
//  hit_seg_idx updates only in a REPORT where sword_hit=1; otherwise it holds its value.
//  Position compares are full POSW-bit equality. Inactive segments never collide.
// TESTING
//  T1 NSEG=7, seg_active=7F, seg3=player=0x45, pulse frame_start:
//     -> done on edge 8; player_hit=1 and player_hurt_evt=1 in the same cycle.
//  T2 Hold T1 overlap for 3 frames:
//     -> player_hit=1 each frame; player_hurt_evt only in frame 1.
//  T3 COOLDOWN=2, overlap in frame 1, none in frame 2, overlap in frame 3:
//     -> no evt in frame 3. Overlap again in frame 5 after clearing -> evt=1.
//  T4 sword=seg2=seg5=0x33, sword_active=1:
//     -> sword_hit=1, hit_seg_idx=2. Repeat with sword_active=0 -> sword_hit=0, idx held at 2.
//  T5 sheep=seg1 -> sheep_hit=0. sheep=seg0 with seg_active[0]=0 -> 0. With seg_active[0]=1:
//     -> sheep_hit=1, heal_evt=1.
//  T6 frame_start pulsed again mid-scan -> exactly one done.
//     rst_n=0 at scan cycle 3 -> no done; all outputs 0.

Source files
------------

// File: rtl/collision_scanner.sv
// collision_scanner: snapshots entity positions each frame and scans dragon segments one per clock,
// producing collision levels and cooldown-gated single-cycle event pulses.
module collision_scanner #(
    parameter int NSEG     = 7,
    parameter int POSW     = 8,
    parameter int COOLDOWN = 30
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 frame_start,
    input  logic [POSW-1:0]      player_pos,
    input  logic [POSW-1:0]      sword_pos,
    input  logic                 sword_active,
    input  logic [POSW-1:0]      sheep_pos,
    input  logic [NSEG*POSW-1:0] seg_pos,
    input  logic [NSEG-1:0]      seg_active,
    output logic                 busy,
    output logic                 done,
    output logic                 player_hit,
    output logic                 sword_hit,
    output logic                 sheep_hit,
    output logic                 player_hurt_evt,
    output logic                 dragon_hit_evt,
    output logic                 dragon_heal_evt,
    output logic [((NSEG > 1) ? $clog2(NSEG) : 1)-1:0] hit_seg_idx
);
    localparam int IW = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int CW = ($clog2(COOLDOWN + 1) > 0) ? $clog2(COOLDOWN + 1) : 1;

    typedef enum logic [1:0] {IDLE, SCAN, REPORT} state_t;

    state_t               state;
    logic [POSW-1:0]      player_q, sword_q, sheep_q;
    logic [NSEG*POSW-1:0] seg_q;
    logic [NSEG-1:0]      act_q;
    logic                 sword_act_q;
    logic [IW-1:0]        idx, acc_idx;
    logic                 acc_p, acc_s, acc_h;
    logic [2:0]           lvl_prev, lvl_new, evt;
    logic [CW-1:0]        cd [3];
    logic [POSW-1:0]      seg;
    logic                 hit_p, hit_s;

    // bit order for lvl/evt/cd: 0 = player/hurt, 1 = sword/hit, 2 = sheep/heal
    always_comb begin
        seg     = seg_q[idx*POSW +: POSW];
        hit_p   = act_q[idx] && seg == player_q;
        hit_s   = act_q[idx] && sword_act_q && seg == sword_q;
        lvl_new = {acc_h, acc_s, acc_p};
        for (int i = 0; i < 3; i++)
            evt[i] = lvl_new[i] & ~lvl_prev[i] & (cd[i] == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            player_hit      <= 1'b0;
            sword_hit       <= 1'b0;
            sheep_hit       <= 1'b0;
            player_hurt_evt <= 1'b0;
            dragon_hit_evt  <= 1'b0;
            dragon_heal_evt <= 1'b0;
            hit_seg_idx     <= '0;
            idx             <= '0;
            acc_idx         <= '0;
            acc_p           <= 1'b0;
            acc_s           <= 1'b0;
            acc_h           <= 1'b0;
            lvl_prev        <= '0;
            cd              <= '{default: '0};
        end else begin
            done            <= 1'b0;
            player_hurt_evt <= 1'b0;
            dragon_hit_evt  <= 1'b0;
            dragon_heal_evt <= 1'b0;
            case (state)
                IDLE: if (frame_start) begin
                    player_q    <= player_pos;
                    sword_q     <= sword_pos;
                    sheep_q     <= sheep_pos;
                    seg_q       <= seg_pos;
                    act_q       <= seg_active;
                    sword_act_q <= sword_active;
                    idx         <= '0;
                    acc_p       <= 1'b0;
                    acc_s       <= 1'b0;
                    acc_h       <= 1'b0;
                    busy        <= 1'b1;
                    state       <= SCAN;
                end
                SCAN: begin
                    acc_p <= acc_p | hit_p;
                    acc_s <= acc_s | hit_s;
                    if (hit_s && !acc_s)
                        acc_idx <= idx;
                    if (idx == '0)
                        acc_h <= act_q[0] && seg == sheep_q;
                    idx <= idx + 1'b1;
                    if (idx == IW'(NSEG - 1))
                        state <= REPORT;
                end
                REPORT: begin
                    {sheep_hit, sword_hit, player_hit}                 <= lvl_new;
                    {dragon_heal_evt, dragon_hit_evt, player_hurt_evt} <= evt;
                    if (acc_s)
                        hit_seg_idx <= acc_idx;
                    lvl_prev <= lvl_new;
                    for (int i = 0; i < 3; i++)
                        cd[i] <= evt[i] ? CW'(COOLDOWN) : (cd[i] != '0 ? cd[i] - 1'b1 : cd[i]);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_collision_scanner.sv
// tb_collision_scanner: directed frames against two scanners (COOLDOWN 30 and 2) sharing inputs;
// expected frame results are queued at frame_start and checked when done appears.
module tb_collision_scanner;
    logic        clk = 1'b0, rst_n = 1'b0, frame_start = 1'b0;
    logic [7:0]  player_pos, sword_pos, sheep_pos;
    logic        sword_active;
    logic [55:0] seg_pos;
    logic [6:0]  seg_active;

    logic busy, done, player_hit, sword_hit, sheep_hit, player_hurt_evt, dragon_hit_evt, dragon_heal_evt;
    logic [2:0] hit_seg_idx;
    logic b_busy, b_done, b_player_hit, b_sword_hit, b_sheep_hit, b_hurt, b_hit, b_heal;
    logic [2:0] b_idx;

    int checks = 0, fails = 0, done_cnt = 0;
    logic [11:0] sb [$];
    logic [11:0] mon_e;
    logic [10:0] out_a, out_b;

    assign out_a = {busy, done, player_hit, sword_hit, sheep_hit, player_hurt_evt, dragon_hit_evt, dragon_heal_evt, hit_seg_idx};
    assign out_b = {b_busy, b_done, b_player_hit, b_sword_hit, b_sheep_hit, b_hurt, b_hit, b_heal, b_idx};

    always #5 clk = ~clk;

    collision_scanner #(.NSEG(7), .POSW(8), .COOLDOWN(30)) u_dut (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .player_pos(player_pos), .sword_pos(sword_pos), .sword_active(sword_active),
        .sheep_pos(sheep_pos), .seg_pos(seg_pos), .seg_active(seg_active),
        .busy(busy), .done(done), .player_hit(player_hit), .sword_hit(sword_hit),
        .sheep_hit(sheep_hit), .player_hurt_evt(player_hurt_evt), .dragon_hit_evt(dragon_hit_evt),
        .dragon_heal_evt(dragon_heal_evt), .hit_seg_idx(hit_seg_idx)
    );

    collision_scanner #(.NSEG(7), .POSW(8), .COOLDOWN(2)) u_cd2 (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start),
        .player_pos(player_pos), .sword_pos(sword_pos), .sword_active(sword_active),
        .sheep_pos(sheep_pos), .seg_pos(seg_pos), .seg_active(seg_active),
        .busy(b_busy), .done(b_done), .player_hit(b_player_hit), .sword_hit(b_sword_hit),
        .sheep_hit(b_sheep_hit), .player_hurt_evt(b_hurt), .dragon_hit_evt(b_hit),
        .dragon_heal_evt(b_heal), .hit_seg_idx(b_idx)
    );

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Scoreboard entry: {p,s,h levels, hit idx, cd30 {hurt,hit,heal}, cd2 {hurt,hit,heal}}
    always @(negedge clk) begin
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected done: got done=1 expected no pending frame");
            end else begin
                mon_e = sb.pop_front();
                check("frame result",
                      {player_hit, sword_hit, sheep_hit, hit_seg_idx, player_hurt_evt, dragon_hit_evt, dragon_heal_evt,
                       b_hurt, b_hit, b_heal, b_done, b_player_hit, b_sword_hit, b_sheep_hit, b_idx},
                      {mon_e, 1'b1, mon_e[11:9], mon_e[8:6]});
            end
        end else begin
            check("idle pulses", {player_hurt_evt, dragon_hit_evt, dragon_heal_evt, b_hurt, b_hit, b_heal, b_done}, 7'b0);
        end
    end

    task automatic run_frame(input logic [2:0] lv, input logic [2:0] idx, input logic [2:0] ea,
                             input logic [2:0] eb, input bit mid, input bit scr);
        int n;
        logic [7:0] keep;
        keep = player_pos;
        @(negedge clk);
        frame_start = 1'b1;
        sb.push_back({lv, idx, ea, eb});
        @(posedge clk);
        #1 frame_start = 1'b0;
        check("busy after start", busy, 1);
        for (n = 1; n <= 20; n++) begin
            @(posedge clk);
            #1;
            if (mid && n == 3) frame_start = 1'b1;
            if (n == 4) frame_start = 1'b0;
            if (scr && n == 2) player_pos = ~keep;
            if (done) break;
        end
        player_pos = keep;
        check("latency", n, 8);
        check("busy after report", busy, 0);
        repeat (2) @(posedge clk);
    endtask

    initial begin
        player_pos   = 8'h00;
        sword_pos    = 8'h01;
        sheep_pos    = 8'h02;
        sword_active = 1'b0;
        seg_active   = 7'h7F;
        for (int i = 0; i < 7; i++) seg_pos[i*8 +: 8] = 8'h10 + 8'(i);
        repeat (2) @(posedge clk);
        #1 check("reset outputs", {out_a, out_b}, 0);
        rst_n = 1'b1;

        seg_pos[3*8 +: 8] = 8'h45;
        player_pos = 8'h45;
        run_frame(3'b100, 3'd0, 3'b100, 3'b100, 0, 0);
        run_frame(3'b100, 3'd0, 3'b000, 3'b000, 0, 0);
        run_frame(3'b100, 3'd0, 3'b000, 3'b000, 0, 1);
        player_pos = 8'h00;
        run_frame(3'b000, 3'd0, 3'b000, 3'b000, 0, 0);
        player_pos = 8'h45;
        run_frame(3'b100, 3'd0, 3'b000, 3'b100, 0, 0);
        player_pos = 8'h00;
        run_frame(3'b000, 3'd0, 3'b000, 3'b000, 0, 0);
        player_pos = 8'h45;
        run_frame(3'b100, 3'd0, 3'b000, 3'b000, 0, 0);
        player_pos = 8'h00;
        run_frame(3'b000, 3'd0, 3'b000, 3'b000, 0, 0);
        player_pos = 8'h45;
        run_frame(3'b100, 3'd0, 3'b000, 3'b100, 0, 0);
        player_pos = 8'h00;
        run_frame(3'b000, 3'd0, 3'b000, 3'b000, 0, 0);

        sword_pos = 8'h33;
        seg_pos[2*8 +: 8] = 8'h33;
        seg_pos[5*8 +: 8] = 8'h33;
        sword_active = 1'b1;
        run_frame(3'b010, 3'd2, 3'b010, 3'b010, 0, 0);
        sword_active = 1'b0;
        run_frame(3'b000, 3'd2, 3'b000, 3'b000, 0, 0);
        sword_active = 1'b1;
        seg_pos[2*8 +: 8] = 8'h12;
        run_frame(3'b010, 3'd5, 3'b000, 3'b000, 0, 0);
        seg_active = 7'h5F;
        run_frame(3'b000, 3'd5, 3'b000, 3'b000, 0, 0);
        seg_active = 7'h7F;
        seg_pos[6*8 +: 8] = 8'h33;
        run_frame(3'b010, 3'd5, 3'b000, 3'b010, 0, 0);

        sword_active = 1'b0;
        sheep_pos = 8'h11;
        run_frame(3'b000, 3'd5, 3'b000, 3'b000, 0, 0);
        sheep_pos  = 8'h10;
        player_pos = 8'h10;
        seg_active = 7'h7E;
        run_frame(3'b000, 3'd5, 3'b000, 3'b000, 0, 0);
        seg_active = 7'h7F;
        run_frame(3'b101, 3'd5, 3'b001, 3'b101, 0, 0);
        run_frame(3'b101, 3'd5, 3'b000, 3'b000, 1, 0);

        // abort a scan with reset after three scan cycles
        @(negedge clk);
        frame_start = 1'b1;
        @(posedge clk);
        #1 frame_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        check("reset mid-scan outputs", {out_a, out_b}, 0);
        repeat (12) @(posedge clk);
        #1 check("outputs after aborted scan", {out_a, out_b}, 0);

        run_frame(3'b101, 3'd0, 3'b101, 3'b101, 0, 0);

        repeat (4) @(posedge clk);
        check("done count", done_cnt, 20);
        check("scoreboard drained", sb.size(), 0);
        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end
endmodule
